// File: rtl/if_fetch_unit_if.sv
// Bundle between the fetch unit and its neighbours: hazard/branch control,
// instruction ROM port, IF/ID boundary and performance counters.
interface if_fetch_unit_if #(
   parameter int AW = 4,
   parameter int IW = 32,
   parameter int CW = 8
);
   logic          stall;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic [AW-1:0] rom_address;
   logic [IW-1:0] rom_q;
   logic [IW-1:0] if_id_inst;
   logic [AW-1:0] if_id_pc;
   logic          if_id_valid;
   logic [CW-1:0] fetch_count;
   logic [CW-1:0] stall_count;

   modport master (
      input  stall, redirect, redirect_pc, rom_q,
      output rom_address, if_id_inst, if_id_pc, if_id_valid,
             fetch_count, stall_count
   );

   modport slave (
      output stall, redirect, redirect_pc, rom_q,
      input  rom_address, if_id_inst, if_id_pc, if_id_valid,
             fetch_count, stall_count
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the registered ROM and
// realigns its one-cycle latency so instruction, PC and valid leave together.
module if_fetch_unit #(
   parameter int AW = 4,
   parameter int IW = 32,
   parameter int CW = 8
) (
   input  logic          clock,
   input  logic          reset,
   if_fetch_unit_if.master bus
);

   typedef enum logic {S_FILL, S_RUN} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_pc_p0;
   logic [AW-1:0] r_inflight_pc_p1;
   logic          r_inflight_vld_p1;
   logic [CW-1:0] r_fetch_cnt;
   logic [CW-1:0] r_stall_cnt;
   logic [AW-1:0] w_rom_addr;
   logic          w_fetch_inc;
   logic          w_stall_inc;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + CW'(1);
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FILL:  w_state_nxt = S_RUN;
         S_RUN:   w_state_nxt = S_RUN;
         default: w_state_nxt = S_FILL;
      endcase
   end

   // A stall re-reads the held address; the ROM is read-only so the data is identical.
   always_comb begin
      w_rom_addr = r_pc_p0;
      if (reset)
         w_rom_addr = '0;
      else if (bus.redirect)
         w_rom_addr = bus.redirect_pc;
      else if (bus.stall)
         w_rom_addr = r_inflight_pc_p1;
   end

   assign w_fetch_inc = r_inflight_vld_p1 && (r_state == S_RUN) && !bus.stall && !bus.redirect;
   assign w_stall_inc = r_inflight_vld_p1 && (r_state == S_RUN) &&  bus.stall && !bus.redirect;

   always_ff @(posedge clock) begin
      r_state <= reset ? S_FILL : w_state_nxt;
   end

   // Stage p0 -> p1: address issued now, instruction returns from the ROM next cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc_p0           <= '0;
         r_inflight_pc_p1  <= '0;
         r_inflight_vld_p1 <= 1'b0;
      end else if (bus.redirect) begin
         r_pc_p0           <= bus.redirect_pc + AW'(1);
         r_inflight_pc_p1  <= bus.redirect_pc;
         r_inflight_vld_p1 <= 1'b1;
      end else if (!bus.stall) begin
         r_pc_p0           <= r_pc_p0 + AW'(1);
         r_inflight_pc_p1  <= r_pc_p0;
         r_inflight_vld_p1 <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_fetch_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_fetch_inc) r_fetch_cnt <= sat_inc(r_fetch_cnt);
         if (w_stall_inc) r_stall_cnt <= sat_inc(r_stall_cnt);
      end
   end

   assign bus.rom_address = w_rom_addr;
   assign bus.if_id_valid = r_inflight_vld_p1;
   assign bus.if_id_pc    = r_inflight_pc_p1;
   assign bus.if_id_inst  = r_inflight_vld_p1 ? bus.rom_q : '0;
   assign bus.fetch_count = r_fetch_cnt;
   assign bus.stall_count = r_stall_cnt;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a registered ROM model inst[i] = 32'h1000_0000 + i.
module tb_if_fetch_unit;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_errors;

   if_fetch_unit_if #(.AW(4), .IW(32), .CW(8)) bus ();

   if_fetch_unit #(.AW(4), .IW(32), .CW(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) bus.rom_q <= 32'h1000_0000 + 32'(bus.rom_address);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Checks the whole IF/ID boundary plus both counters for one cycle.
   task automatic expect_out(input string tag, input logic v, input int pc, input int fc, input int sc);
      check({tag, ".valid"}, 32'(bus.if_id_valid), 32'(v));
      check({tag, ".inst"},  bus.if_id_inst, v ? 32'h1000_0000 + 32'(pc % 16) : 32'h0);
      check({tag, ".pc"},    32'(bus.if_id_pc), 32'(pc % 16));
      check({tag, ".fcnt"},  32'(bus.fetch_count), 32'(fc));
      check({tag, ".scnt"},  32'(bus.stall_count), 32'(sc));
   endtask

   initial begin
      n_checks        = 0;
      n_errors        = 0;
      reset           = 1'b1;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      step();
      step();
      expect_out("rst", 1'b0, 0, 0, 0);
      check("rst.addr", 32'(bus.rom_address), 32'h0);

      // Cycle 1 (FILL) then straight-line run: at cycle n, pc=(n-2)%16, fetch_count=n-2.
      reset = 1'b0;
      expect_out("fill", 1'b0, 0, 0, 0);
      check("fill.addr", 32'(bus.rom_address), 32'h0);
      for (int n = 2; n <= 20; n++) begin
         step();
         expect_out("run", 1'b1, n - 2, n - 2, 0);
      end

      // Cycle 21: pc=3, redirect to 12.
      step();
      expect_out("pre_redir", 1'b1, 3, 19, 0);
      bus.redirect = 1'b1;
      bus.redirect_pc = 4'd12;
      #1;
      check("redir.addr", 32'(bus.rom_address), 32'd12);
      step();
      bus.redirect = 1'b0;
      expect_out("redir_tgt", 1'b1, 12, 19, 0);
      step();
      expect_out("redir_nxt", 1'b1, 13, 20, 0);

      // Cycle 23: redirect to 15 together with stall; redirect wins, nothing counted.
      bus.redirect = 1'b1;
      bus.stall = 1'b1;
      bus.redirect_pc = 4'd15;
      #1;
      check("rs.addr", 32'(bus.rom_address), 32'd15);
      step();
      bus.redirect = 1'b0;
      bus.stall = 1'b0;
      expect_out("rs_tgt", 1'b1, 15, 20, 0);
      step();
      expect_out("rs_wrap", 1'b1, 0, 21, 0);

      // Cycle 25: redirect to 5, then stall two cycles at pc 5.
      bus.redirect = 1'b1;
      bus.redirect_pc = 4'd5;
      step();
      bus.redirect = 1'b0;
      expect_out("st0", 1'b1, 5, 21, 0);
      bus.stall = 1'b1;
      #1;
      check("st.addr", 32'(bus.rom_address), 32'd5);
      step();
      expect_out("st1", 1'b1, 5, 21, 1);
      step();
      bus.stall = 1'b0;
      expect_out("st2", 1'b1, 5, 21, 2);
      step();
      expect_out("st_rel", 1'b1, 6, 22, 2);
      step();
      step();
      step();
      expect_out("pre_rst", 1'b1, 9, 25, 2);

      // Cycle 32: reset overriding redirect and stall.
      reset = 1'b1;
      bus.redirect = 1'b1;
      bus.stall = 1'b1;
      bus.redirect_pc = 4'd7;
      #1;
      check("mrst.addr", 32'(bus.rom_address), 32'h0);
      step();
      reset = 1'b0;
      bus.redirect = 1'b0;
      expect_out("mrst", 1'b0, 0, 0, 0);
      #1;
      check("mrst.addr2", 32'(bus.rom_address), 32'h0);

      // Cycle 33: stall while output invalid holds state and counts nothing.
      step();
      bus.stall = 1'b0;
      expect_out("st_inv", 1'b0, 0, 0, 0);
      step();
      expect_out("mrst_pc0", 1'b1, 0, 0, 0);

      // Cycle 35: fetch_count = m-35; drive it up to saturation.
      for (int k = 0; k < 254; k++) step();
      check("sat254", 32'(bus.fetch_count), 32'd254);
      step();
      check("sat255", 32'(bus.fetch_count), 32'd255);
      for (int k = 0; k < 5; k++) step();
      check("sat_hold", 32'(bus.fetch_count), 32'd255);
      check("sat_pc", 32'(bus.if_id_pc), 32'((254 + 1 + 5) % 16));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the pipelined CPU. It owns the program counter, drives the 4-bit address of the 16-word registered instruction ROM, and realigns the ROM's one-cycle read latency. It presents each fetched instruction with its PC and a valid flag to the IF/ID boundary. It also handles decode-stage stalls, taken-branch redirects, and two saturating performance counters.

## Interface
Parameters:
- AW, 4, instruction address width (matches 16-word ROM)
- IW, 32, instruction width
- CW, 8, performance counter width

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high (fixed)
- stall  in  1  from hazard unit: decode does not accept current instruction
- redirect  in  1  taken branch/jump resolved downstream
- redirect_pc  in  AW  branch target
- rom_address  out  AW  to instruction ROM address input (combinational)
- rom_q  in  IW  ROM registered data, valid one cycle after address
- if_id_inst  out  IW  fetched instruction; 0 (NOP) when invalid
- if_id_pc  out  AW  PC of if_id_inst
- if_id_valid  out  1  if_id_inst is a real instruction
- fetch_count  out  CW  saturating count of accepted instructions
- stall_count  out  CW  saturating count of cycles with stall && if_id_valid

## Operation
- Registers: pc (next address to issue), inflight_pc, inflight_valid, state, two counters.
- FSM: FILL (first issue after reset; output invalid) -> RUN (unconditional after one cycle). Reset forces FILL.
- rom_address mux, priority order: reset -> 0; redirect -> redirect_pc; stall -> inflight_pc (re-read held instruction; ROM is read-only so re-read is exact); else pc.
- Edge updates:
  - redirect: pc <= redirect_pc+1, inflight_pc <= redirect_pc, inflight_valid <= 1. Current output is squashed by downstream and is not counted.
  - stall (no redirect): pc, inflight_* hold.
  - normal: inflight_pc <= pc, inflight_valid <= 1, pc <= pc+1.
- Outputs: if_id_valid = inflight_valid; if_id_pc = inflight_pc; if_id_inst = inflight_valid ? rom_q : 0.
- PC arithmetic is modulo 2^AW. 15+1 wraps to 0 with no flag. redirect_pc 15 gives next pc 0.
- fetch_count increments when if_id_valid && !stall && !redirect. stall_count increments when if_id_valid && stall && !redirect. Both hold at 2^CW-1.

## Timing
- Reset values (cycle after reset-high edge): pc=0, inflight_pc=0, inflight_valid=0, if_id_valid=0, if_id_inst=0, if_id_pc=0, counters=0, state=FILL. rom_address=0 while reset is high.
- First fetch: issue 0 in FILL cycle. Instruction at 0 appears valid the next cycle. Throughput is 1 instruction/cycle thereafter.
- Fetch latency: address presented in cycle t -> if_id_* valid in cycle t+1.
- Redirect latency: redirect in cycle t -> target instruction on if_id in cycle t+1 (one squashed slot, namely the cycle-t output).
- redirect together with stall: redirect wins.
- stall while if_id_valid=0: state holds, no counting.
- Reset mid-operation overrides redirect and stall. In-flight instruction is discarded. Sequence restarts from FILL at pc 0.

## Test plan
- ROM model inst[i]=32'h1000_0000+i. Deassert reset -> cycle 1 if_id_valid=0, inst=0; cycle 2 inst=32'h1000_0000, pc=0; cycle 3 pc=1.
- Straight-line run of 18 cycles from reset -> if_id_pc sequence 0..15,0,1. fetch_count=18 then continues, with no gap at the wrap.
- Stall asserted 2 cycles while if_id_pc=5 -> pc 5 held 3 cycles with inst 32'h1000_0005, then 6 next. stall_count=2.
- Redirect to 12 while if_id_pc=3 -> next cycle if_id_pc=12, inst 32'h1000_000C, then 13. pc 3 not counted.
- Redirect to 15 with stall high -> next if_id_pc=15, then 0. Redirect beats stall.
- Reset asserted for one cycle while if_id_pc=9 -> next cycle if_id_valid=0, counters 0, rom_address=0. Then pc 0 valid the following cycle.
- Force fetch_count to 254 -> saturates at 255 and holds.
